// File: rtl/ingress_frame_writer.sv
// ingress_frame_writer: AXIS ingress to frame buffer plus per-frame sideband {end_ptr, tdest}, type filter and length drop.
// Define INGRESS_STATS_EN to add saturating accepted/dropped frame counters.
module ingress_frame_writer #(
   parameter int ADDR_WIDTH   = 11,
   parameter int HDR_TYPE_IDX = 0,
   parameter int MAX_WORDS    = 1024,
   parameter int DEST_WIDTH   = 4
) (
`ifdef INGRESS_STATS_EN
   output logic [15:0]           stat_accepted,
   output logic [15:0]           stat_dropped,
`endif
   input  logic                  clk,
   input  logic                  reset,
   input  logic [15:0]           ingress_tdata,
   input  logic                  ingress_tvalid,
   input  logic                  ingress_tlast,
   input  logic [DEST_WIDTH-1:0] ingress_tdest,
   output logic                  ingress_tready,
   input  logic                  filter_en,
   input  logic [15:0]           filter_type,
   output logic [15:0]           frame_wdata,
   output logic                  frame_wen,
   input  logic                  frame_full,
   input  logic [ADDR_WIDTH:0]   frame_wptr,
   output logic                  frame_wrst,
   output logic [ADDR_WIDTH:0]   frame_rst_wptr,
   output logic [19:0]           sideband_wdata,
   output logic                  sideband_wen,
   input  logic                  sideband_full,
   output logic                  scan_payload
);
   typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, DROP, COMMIT, REWIND} state_t;
   state_t state, state_n;
   logic [ADDR_WIDTH:0] wcnt, idx, cnt_n, end_ptr;
   logic [DEST_WIDTH-1:0] dest_q;
   logic armed, hs, wr_st, hit, maxed, pre_hdr;
   assign wr_st = state == IDLE || state == HEADER || state == PAYLOAD;
   assign end_ptr = frame_rst_wptr + wcnt;
   assign sideband_wdata = 20'({end_ptr, dest_q});
   assign sideband_wen = state == COMMIT;
   always_comb begin
      idx = state == IDLE ? '0 : wcnt;
      cnt_n = idx + 1'b1;
      hit = filter_en && ingress_tdata == filter_type;
      maxed = int'(cnt_n) >= MAX_WORDS;
      pre_hdr = int'(idx) < HDR_TYPE_IDX;
      // after a rewind the new start pointer lands one cycle later, so hold off until frame_wrst clears
      ingress_tready = state == IDLE ? armed & ~frame_wrst & ~frame_full & ~sideband_full :
                       (state == HEADER || state == PAYLOAD) ? ~frame_full : state == DROP;
      hs = ingress_tvalid & ingress_tready;
      state_n = state;
      case (state)
         IDLE, HEADER: if (hs) state_n = pre_hdr ? (ingress_tlast ? REWIND : HEADER) :
                                         hit ? (ingress_tlast ? REWIND : DROP) :
                                         ingress_tlast ? COMMIT : maxed ? DROP : PAYLOAD;
         PAYLOAD: if (hs) state_n = ingress_tlast ? COMMIT : maxed ? DROP : PAYLOAD;
         DROP: if (hs && ingress_tlast) state_n = REWIND;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         armed <= 1'b0;
         wcnt <= '0;
         dest_q <= '0;
         frame_rst_wptr <= '0;
         frame_wdata <= '0;
         frame_wen <= 1'b0;
         frame_wrst <= 1'b0;
         scan_payload <= 1'b0;
      end else begin
         state <= state_n;
         armed <= 1'b1;
         frame_wen <= hs && wr_st;
         if (hs && wr_st) begin
            frame_wdata <= ingress_tdata;
            wcnt <= cnt_n;
         end
         if (hs && state == IDLE) begin
            frame_rst_wptr <= frame_wptr;
            dest_q <= ingress_tdest;
         end
         frame_wrst <= state == REWIND;
         scan_payload <= state == PAYLOAD;
      end
   end
`ifdef INGRESS_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_accepted <= '0;
         stat_dropped <= '0;
      end else begin
         if (state == COMMIT && stat_accepted != 16'hFFFF) stat_accepted <= stat_accepted + 1'b1;
         if (state == REWIND && stat_dropped != 16'hFFFF) stat_dropped <= stat_dropped + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_ingress_frame_writer.sv
// tb_ingress_frame_writer: directed frames against a small frame-buffer pointer model and sideband monitor.
module tb_ingress_frame_writer;
   logic clk = 1'b0, reset = 1'b1;
   logic [15:0] tdata = '0, filter_type = '0;
   logic tvalid = 1'b0, tlast = 1'b0, filter_en = 1'b0, frame_full = 1'b0, sideband_full = 1'b0;
   logic [3:0] tdest = '0;
   logic tready, frame_wen, frame_wrst, sideband_wen, scan_payload;
   logic [15:0] frame_wdata;
   logic [11:0] frame_rst_wptr, wptr = '0, wptr_val = '0;
   logic [19:0] sideband_wdata, sb_last = '0;
   logic wptr_load = 1'b0, scan_seen = 1'b0;
   logic [15:0] mem [4096];
   int checks = 0, failures = 0, wen_cnt = 0, sb_cnt = 0, wrst_cnt = 0, stall_low = 0;
   int start, wen0, sb0, wrst0;
`ifdef INGRESS_STATS_EN
   logic [15:0] stat_accepted, stat_dropped;
`endif
   ingress_frame_writer dut (
`ifdef INGRESS_STATS_EN
      .stat_accepted(stat_accepted), .stat_dropped(stat_dropped),
`endif
      .clk(clk), .reset(reset), .ingress_tdata(tdata), .ingress_tvalid(tvalid), .ingress_tlast(tlast),
      .ingress_tdest(tdest), .ingress_tready(tready), .filter_en(filter_en), .filter_type(filter_type),
      .frame_wdata(frame_wdata), .frame_wen(frame_wen), .frame_full(frame_full), .frame_wptr(wptr),
      .frame_wrst(frame_wrst), .frame_rst_wptr(frame_rst_wptr), .sideband_wdata(sideband_wdata),
      .sideband_wen(sideband_wen), .sideband_full(sideband_full), .scan_payload(scan_payload));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (wptr_load) wptr <= wptr_val;
      else if (frame_wrst) wptr <= frame_rst_wptr;
      else if (frame_wen) begin
         mem[wptr] <= frame_wdata;
         wptr <= wptr + 1'b1;
      end
      if (frame_wen) wen_cnt <= wen_cnt + 1;
      if (frame_wrst) wrst_cnt <= wrst_cnt + 1;
      if (sideband_wen) begin
         sb_cnt <= sb_cnt + 1;
         sb_last <= sideband_wdata;
      end
      if (scan_payload) scan_seen <= 1'b1;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [15:0] word(input int i, input logic [15:0] w0);
      return i == 0 ? w0 : 16'h1000 + 16'(i);
   endfunction
   task automatic send(input int n, input logic [15:0] w0, input logic [3:0] dest, input int stall_at, input bit last);
      bit h;
      int t;
      for (int i = 0; i < n; i++) begin
         tvalid = 1'b1;
         tdata = word(i, w0);
         tlast = last && i == n - 1;
         tdest = i == 0 ? dest : ~dest;
         if (i == stall_at) begin
            frame_full = 1'b1;
            repeat (3) begin
               #1 stall_low += int'(!tready);
               @(negedge clk);
            end
            frame_full = 1'b0;
         end
         t = 0;
         do begin
            #1 h = tready;
            @(posedge clk);
            @(negedge clk);
            t++;
         end while (!h && t < 200);
         if (!h) chk("beat_timeout", 0, 1);
      end
      tvalid = 1'b0;
      tlast = 1'b0;
   endtask
   task automatic mark;
      start = int'(wptr);
      wen0 = wen_cnt;
      sb0 = sb_cnt;
      wrst0 = wrst_cnt;
      scan_seen = 1'b0;
   endtask
   initial begin
      wptr_load = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_tready", tready, 0);
      chk("rst_outs", {frame_wen, sideband_wen, frame_wrst, scan_payload}, 0);
      chk("rst_data", {frame_wdata, sideband_wdata, frame_rst_wptr}, 0);
      @(negedge clk);
      reset = 1'b0;
      wptr_load = 1'b0;
      repeat (2) @(negedge clk);
      // 1: plain 4-word frame
      mark();
      send(4, 16'h1234, 4'd2, -1, 1);
      repeat (4) @(negedge clk);
      chk("t1_wen", wen_cnt - wen0, 4);
      chk("t1_sb_cnt", sb_cnt - sb0, 1);
      chk("t1_sb_data", sb_last, 20'h00042);
      chk("t1_scan_seen", scan_seen, 1);
      chk("t1_scan_low", scan_payload, 0);
      chk("t1_word0", mem[0], 16'h1234);
      // 2: filter hit on word 0 drops and rewinds
      filter_en = 1'b1;
      filter_type = 16'h0800;
      mark();
      send(6, 16'h0800, 4'd1, -1, 1);
      repeat (4) @(negedge clk);
      chk("t2_sb_cnt", sb_cnt - sb0, 0);
      chk("t2_wen", wen_cnt - wen0, 1);
      chk("t2_wrst", wrst_cnt - wrst0, 1);
      chk("t2_rst_wptr", frame_rst_wptr, 12'd4);
      chk("t2_wptr", wptr, 12'd4);
      chk("t2_scan_seen", scan_seen, 0);
`ifdef INGRESS_STATS_EN
      chk("t2_stat_dropped", stat_dropped, 1);
      chk("t2_stat_accepted", stat_accepted, 1);
`endif
      // 3: filter miss, frame_full stall for 3 cycles mid-payload
      mark();
      stall_low = 0;
      send(6, 16'h0801, 4'd5, 3, 1);
      repeat (4) @(negedge clk);
      chk("t3_stall", stall_low, 3);
      chk("t3_sb_cnt", sb_cnt - sb0, 1);
      chk("t3_sb_data", sb_last, 20'h000A5);
      for (int i = 0; i < 6; i++) chk("t3_data", mem[12'(start + i)], word(i, 16'h0801));
      filter_en = 1'b0;
      // 4: pointer wrap
      wptr_val = 12'hFFE;
      wptr_load = 1'b1;
      @(negedge clk);
      wptr_load = 1'b0;
      mark();
      send(5, 16'hBEEF, 4'd7, -1, 1);
      repeat (4) @(negedge clk);
      chk("t4_sb_data", sb_last, 20'h00037);
      chk("t4_wptr", wptr, 12'h003);
      chk("t4_wrap_lo", mem[12'hFFE], 16'hBEEF);
      chk("t4_wrap_hi", mem[12'h002], 16'h1004);
      // 5: oversize frame dropped after MAX_WORDS, next frame accepted
      mark();
      send(1027, 16'h0001, 4'd3, -1, 1);
      repeat (4) @(negedge clk);
      chk("t5_wen", wen_cnt - wen0, 1024);
      chk("t5_sb_cnt", sb_cnt - sb0, 0);
      chk("t5_wrst", wrst_cnt - wrst0, 1);
      chk("t5_wptr", wptr, 12'h003);
      send(2, 16'h0002, 4'd9, -1, 1);
      repeat (4) @(negedge clk);
      chk("t5_next_sb", sb_last, 20'h00059);
      chk("t5_next_cnt", sb_cnt - sb0, 1);
      // 6: reset mid-payload
      mark();
      send(4, 16'h0003, 4'd4, -1, 0);
      chk("t6_scan_pre", scan_payload, 1);
      reset = 1'b1;
      #1;
      chk("t6_rst_outs", {tready, frame_wen, sideband_wen, frame_wrst, scan_payload}, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("t6_no_sb", sb_cnt - sb0, 0);
      mark();
      send(3, 16'h0004, 4'd6, -1, 1);
      repeat (4) @(negedge clk);
      chk("t6_next_cnt", sb_cnt - sb0, 1);
      chk("t6_next_sb", sb_last, {4'h0, 12'(start + 3), 4'd6});
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
